// File: rtl/cpu_pkg.sv
// Shared CPU definitions: physical address width, prefetch FSM states and
// the segment:offset to physical address helper.
package cpu_pkg;

  localparam int unsigned PHYS_ADDR_W = 20;

  typedef enum logic {
    IDLE,
    REQ
  } pf_state_e;

  function automatic logic [PHYS_ADDR_W-1:0] phys_addr(input logic [15:0] cs,
                                                       input logic [15:0] ip);
    return {cs, 4'b0000} + {4'b0000, ip};
  endfunction

endpackage

// File: rtl/prefetch_if.sv
// Prefetch stage bus: CS/redirect inputs, instruction FIFO write port and
// memory read port. master = prefetch side, slave = environment side.
interface prefetch_if;
  import cpu_pkg::*;

  logic [15:0]              cs;
  logic [15:0]              new_ip;
  logic                     load_new_ip;
  logic                     fifo_wr_en;
  logic [7:0]               fifo_wr_data;
  logic                     fifo_reset;
  logic                     fifo_full;
  logic                     mem_access;
  logic                     mem_ack;
  logic [PHYS_ADDR_W-2:0]   mem_address;
  logic [15:0]              mem_data;

  modport master (
    input  cs, new_ip, load_new_ip, fifo_full, mem_ack, mem_data,
    output fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
  );

  modport slave (
    output cs, new_ip, load_new_ip, fifo_full, mem_ack, mem_data,
    input  fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
  );

endinterface

// File: rtl/prefetch_byte_buffer.sv
// Two-byte shift buffer between the memory word and the instruction FIFO;
// the lowest pending byte is always presented on the FIFO write port.
module prefetch_byte_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        load_two_i,
  input  logic [15:0] load_data_i,
  input  logic        fifo_full_i,
  output logic        wr_en_o,
  output logic [7:0]  wr_data_o,
  output logic [1:0]  count_o
);

  logic [15:0] buf_q, buf_d;
  logic [1:0]  count_q, count_d;

  assign wr_en_o   = (count_q != 2'd0) & ~fifo_full_i & ~flush_i;
  assign wr_data_o = buf_q[7:0];
  assign count_o   = count_q;

  // A single-byte load comes from an odd IP, so only the high byte is wanted.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (load_i) begin
      if (load_two_i) begin
        buf_d   = load_data_i;
        count_d = 2'd2;
      end else begin
        buf_d   = {8'h00, load_data_i[15:8]};
        count_d = 2'd1;
      end
    end else if (wr_en_o) begin
      buf_d   = {8'h00, buf_q[15:8]};
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prefetch.sv
// Instruction prefetch: fetches 16-bit words at CS:IP, splits them into bytes
// for the instruction FIFO, and handles redirects including in-flight fetches.
module prefetch
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  prefetch_if.master bus
);

  pf_state_e              state_q;
  logic [15:0]            fetch_ip_q;
  logic                   abort_q;
  logic                   mem_access_q;
  logic [PHYS_ADDR_W-2:0] mem_address_q;
  logic                   fifo_reset_q;

  logic [1:0]             buf_count;
  logic                   accept;
  logic                   start_req;
  logic [PHYS_ADDR_W-2:0] req_word;
  logic                   phys_lsb_unused;

  assign {req_word, phys_lsb_unused} = phys_addr(bus.cs, fetch_ip_q);

  assign accept    = (state_q == REQ) & bus.mem_ack & ~abort_q & ~bus.load_new_ip;
  assign start_req = (state_q == IDLE) & (buf_count == 2'd0) & ~bus.load_new_ip;

  // The bus forbids dropping a request, so a redirect while waiting only marks
  // the returning data for discard; the new fetch starts once it has arrived.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_ip_q    <= '0;
      abort_q       <= 1'b0;
      mem_access_q  <= 1'b0;
      mem_address_q <= '0;
      fifo_reset_q  <= 1'b0;
    end else begin
      fifo_reset_q <= bus.load_new_ip;
      unique case (state_q)
        IDLE: begin
          if (start_req) begin
            state_q       <= REQ;
            mem_access_q  <= 1'b1;
            mem_address_q <= req_word;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state_q      <= IDLE;
            mem_access_q <= 1'b0;
            abort_q      <= 1'b0;
          end else if (bus.load_new_ip) begin
            abort_q <= 1'b1;
          end
        end
      endcase
      if (bus.load_new_ip) begin
        fetch_ip_q <= bus.new_ip;
      end else if (accept) begin
        fetch_ip_q <= fetch_ip_q + (fetch_ip_q[0] ? 16'd1 : 16'd2);
      end
    end
  end

  assign bus.mem_access  = mem_access_q;
  assign bus.mem_address = mem_address_q;
  assign bus.fifo_reset  = fifo_reset_q;

  prefetch_byte_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.load_new_ip),
    .load_i      (accept),
    .load_two_i  (~fetch_ip_q[0]),
    .load_data_i (bus.mem_data),
    .fifo_full_i (bus.fifo_full),
    .wr_en_o     (bus.fifo_wr_en),
    .wr_data_o   (bus.fifo_wr_data),
    .count_o     (buf_count)
  );

endmodule
